// File: rtl/cpu_mem_loader_if.sv
// rtl/cpu_mem_loader_if.sv - host word-stream and dump-stream bundle for cpu_mem_loader
//
// Purpose: groups the two host-facing handshake streams of the loader.
//   in_valid/in_ready/in_data    : host -> loader word stream (64-bit words)
//   out_valid/out_ready/out_data : loader -> host dump stream (64-bit words)
// Modports: master = host side, slave = loader side.
interface cpu_mem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cpu_mem_loader.sv
// rtl/cpu_mem_loader.sv - loads instruction/data memories, runs the CPU, dumps data memory
//
// Purpose: one session per start pulse: load imem_len instruction words, load dmem_len
// data words, hold cpu_enable for run_cycles cycles, then stream dmem_len data words back.
// Ports:
//   clk, srst                  : clock, synchronous active-high reset
//   start                      : one-cycle session start (accepted only in IDLE)
//   imem_len, dmem_len         : word counts, latched on start and clamped to capacity
//   run_cycles                 : cpu_enable duration, latched on start
//   host (slave)               : host word stream in, dump stream out
//   cpu_enable                 : CPU enable
//   addr_ext..wdata_ext        : instruction-memory port (write only, ren_ext tied 0)
//   addr_ext_2..rdata_ext_2    : data-memory port (read data one cycle after ren_ext_2)
//   busy, done                 : session active, one-cycle completion pulse
module cpu_mem_loader #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic [8:0]  imem_len,
  input  logic [8:0]  dmem_len,
  input  logic [31:0] run_cycles,
  cpu_mem_loader_if.slave host,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE
  } state_t;

  localparam logic [8:0] IMAX = 9'(IMEM_WORDS);
  localparam logic [8:0] DMAX = 9'(DMEM_WORDS);

  state_t      state, state_nx;
  logic [8:0]  i_len, d_len, cnt;
  logic [31:0] run_len, run_cnt;
  logic        wen_q, wen2_q, done_q;
  logic [63:0] waddr_q, waddr2_q, wdata2_q, out_q;
  logic [31:0] wdata_q;

  logic [8:0]  i_clamp, d_clamp, sel_d;
  logic [31:0] sel_r;
  logic        hs, cnt_clr, cnt_inc, run_inc;
  logic        in_ready_c, out_valid_c, cpu_en_c, ren2_c;
  state_t      after_i, after_d, after_run;

  assign i_clamp = (imem_len > IMAX) ? IMAX : imem_len;
  assign d_clamp = (dmem_len > DMAX) ? DMAX : dmem_len;

  // Leaving IDLE the lengths are not latched yet, so the skip decisions use the inputs.
  assign sel_d = (state == IDLE) ? d_clamp : d_len;
  assign sel_r = (state == IDLE) ? run_cycles : run_len;

  // Skip chain: each phase falls through to the next phase with a non-zero count.
  assign after_run = (sel_d != 9'd0) ? DUMP_RD : DONE;
  assign after_d   = (sel_r != 32'd0) ? RUN : after_run;
  assign after_i   = (sel_d != 9'd0) ? LOAD_D : after_d;

  assign hs = host.in_valid && in_ready_c;

  always_comb begin
    state_nx    = state;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    run_inc     = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    cpu_en_c    = 1'b0;
    ren2_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (i_clamp != 9'd0) ? LOAD_I : after_i;
          cnt_clr  = 1'b1;
        end
      end
      LOAD_I: begin
        in_ready_c = 1'b1;
        if (hs) begin
          if (cnt == i_len - 9'd1) begin
            state_nx = after_i;
            cnt_clr  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      LOAD_D: begin
        in_ready_c = 1'b1;
        if (hs) begin
          if (cnt == d_len - 9'd1) begin
            state_nx = after_d;
            cnt_clr  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      RUN: begin
        // The last load write lands in the first RUN cycle; hold the CPU off until it retires.
        cpu_en_c = !(wen_q || wen2_q);
        if (cpu_en_c) begin
          if (run_cnt == run_len - 32'd1) state_nx = after_run;
          else                            run_inc  = 1'b1;
        end
      end
      DUMP_RD: begin
        // A trailing data write may still own port 2 when RUN was skipped.
        ren2_c = !wen2_q;
        if (ren2_c) state_nx = DUMP_WAIT;
      end
      DUMP_WAIT: state_nx = DUMP_OUT;
      DUMP_OUT: begin
        out_valid_c = 1'b1;
        if (host.out_ready) begin
          if (cnt == d_len - 9'd1) begin
            state_nx = DONE;
            cnt_clr  = 1'b1;
          end else begin
            state_nx = DUMP_RD;
            cnt_inc  = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= IDLE;
      i_len    <= '0;
      d_len    <= '0;
      run_len  <= '0;
      cnt      <= '0;
      run_cnt  <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wen2_q   <= 1'b0;
      waddr2_q <= '0;
      wdata2_q <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        i_len   <= i_clamp;
        d_len   <= d_clamp;
        run_len <= run_cycles;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 9'd1;
      if (state_nx != RUN) run_cnt <= '0;
      else if (run_inc)    run_cnt <= run_cnt + 32'd1;
      // Writes are issued the cycle after the handshake; idle cycles drive zeros.
      wen_q    <= (state == LOAD_I) && hs;
      waddr_q  <= ((state == LOAD_I) && hs) ? {53'd0, cnt, 2'b00} : 64'd0;
      wdata_q  <= ((state == LOAD_I) && hs) ? host.in_data[31:0] : 32'd0;
      wen2_q   <= (state == LOAD_D) && hs;
      waddr2_q <= ((state == LOAD_D) && hs) ? {52'd0, cnt, 3'b000} : 64'd0;
      wdata2_q <= ((state == LOAD_D) && hs) ? host.in_data : 64'd0;
      if (state == DUMP_WAIT) out_q <= rdata_ext_2;
      // done is registered: it pulses the cycle after DONE.
      done_q <= (state == DONE);
    end
  end

  assign host.in_ready  = in_ready_c;
  assign host.out_valid = out_valid_c;
  assign host.out_data  = out_valid_c ? out_q : 64'd0;
  assign cpu_enable     = cpu_en_c;
  assign addr_ext       = waddr_q;
  assign wen_ext        = wen_q;
  assign ren_ext        = 1'b0;
  assign wdata_ext      = wdata_q;
  assign wen_ext_2      = wen2_q;
  assign ren_ext_2      = ren2_c;
  assign addr_ext_2     = wen2_q ? waddr2_q : (ren2_c ? {52'd0, cnt, 3'b000} : 64'd0);
  assign wdata_ext_2    = wdata2_q;
  assign busy           = (state != IDLE);
  assign done           = done_q;
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb/tb_cpu_mem_loader.sv - self-checking bench for cpu_mem_loader
module tb_cpu_mem_loader;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst, start;
  logic [8:0]  imem_len, dmem_len;
  logic [31:0] run_cycles;
  logic        cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic [31:0] wdata_ext;

  cpu_mem_loader_if bus ();

  cpu_mem_loader dut (
    .clk(clk), .srst(srst), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .run_cycles(run_cycles),
    .host(bus), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  // Data-memory model: synchronous write, read data one cycle after ren_ext_2.
  logic [63:0] dmem [0:127];
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[9:3]] <= wdata_ext_2;
    rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[9:3]] : 64'd0;
  end

  int checks = 0;
  int errors = 0;
  int sess = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] iword(input int k);
    return 32'hA500_0000 ^ (32'(sess) << 16) ^ 32'(k);
  endfunction

  function automatic logic [63:0] dword(input int k);
    return {32'hD000_0000 | 32'(sess), 32'h1234_0000 + 32'(k)};
  endfunction

  // Monitor, sampled mid-cycle after the drivers have settled.
  int iw_cnt, dw_cnt, rd_cnt, en_cnt, en_bursts, dump_cnt, done_cnt, stall_obs, done_cyc;
  logic [63:0] last_iaddr, prev_d;
  logic prev_en, prev_v, prev_r;
  bit mon_on = 0;

  always @(negedge clk) begin
    #3;
    if (mon_on) begin
      check("ren_ext_low", {63'd0, ren_ext}, 64'd0);
      check("no_strobe_in_run", {63'd0, cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2)}, 64'd0);
      check("port1_idle_zero", {63'd0, !wen_ext && (addr_ext != 0 || wdata_ext != 0)}, 64'd0);
      check("port2_idle_zero",
            {63'd0, !wen_ext_2 && !ren_ext_2 && (addr_ext_2 != 0 || wdata_ext_2 != 0)}, 64'd0);
      if (wen_ext) begin
        check("iaddr", addr_ext, 64'(4 * iw_cnt));
        check("idata", {32'd0, wdata_ext}, {32'd0, iword(iw_cnt)});
        last_iaddr = addr_ext;
        iw_cnt++;
      end
      if (wen_ext_2) begin
        check("daddr", addr_ext_2, 64'(8 * dw_cnt));
        check("ddata", wdata_ext_2, dword(dw_cnt));
        dw_cnt++;
      end
      if (ren_ext_2) begin
        check("raddr", addr_ext_2, 64'(8 * rd_cnt));
        rd_cnt++;
      end
      if (cpu_enable) begin
        en_cnt++;
        if (!prev_en) en_bursts++;
      end
      if (prev_v && !prev_r) begin
        check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        check("hold_data", bus.out_data, prev_d);
      end
      if (bus.out_valid && !bus.out_ready) stall_obs++;
      if (bus.out_valid && bus.out_ready) begin
        check("dump_data", bus.out_data, dword(dump_cnt));
        dump_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_en = cpu_enable;
    prev_v  = bus.out_valid;
    prev_r  = bus.out_ready;
    prev_d  = bus.out_data;
  end

  typedef struct {
    logic [8:0]  il;
    logic [8:0]  dl;
    logic [31:0] rc;
    bit          toggle;
    bit          stall;
    int          ei;
    int          ed;
    int          stall_exp;
    int          done_at;
  } vec_t;

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {55'd0, cpu_enable, bus.in_ready, bus.out_valid, busy, done,
                          wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'd0);
    check({tag, "_addr"}, addr_ext | addr_ext_2, 64'd0);
    check({tag, "_data"}, {32'd0, wdata_ext} | wdata_ext_2 | bus.out_data, 64'd0);
  endtask

  task automatic run_session(input vec_t v);
    int idx = 0;
    bit hs = 0;
    bit got = 0;
    int stall_n = 0;
    int total = v.ei + v.ed;
    sess++;
    iw_cnt = 0; dw_cnt = 0; rd_cnt = 0; en_cnt = 0; en_bursts = 0;
    dump_cnt = 0; done_cnt = 0; stall_obs = 0; done_cyc = -1; last_iaddr = '0;
    @(negedge clk);
    imem_len = v.il; dmem_len = v.dl; run_cycles = v.rc; start = 1'b1;
    cyc = 0;
    mon_on = 1;
    for (int n = 1; n < 5000; n++) begin
      @(negedge clk);
      cyc = n;
      if (n == 1) begin
        // Changing the inputs after start must not affect the session.
        start = 1'b0; imem_len = 9'h1ff; dmem_len = 9'h1ff; run_cycles = 32'd7;
      end
      if (n == 3 && busy) start = 1'b1;
      if (n == 4) start = 1'b0;
      if (hs) idx++;
      bus.in_valid = (idx < total) && (!v.toggle || (n % 2 == 1));
      bus.in_data  = (idx < v.ei) ? {32'hFFFF_FFFF, iword(idx)} : dword(idx - v.ei);
      if (v.stall && bus.out_valid && stall_n < 4) begin
        bus.out_ready = 1'b0;
        stall_n++;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      hs = bus.in_valid && bus.in_ready;
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    if (!got) check("session_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
    #4;
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_done", {63'd0, done}, 64'd0);
    check("imem_writes", 64'(iw_cnt), 64'(v.ei));
    check("dmem_writes", 64'(dw_cnt), 64'(v.ed));
    check("dmem_reads", 64'(rd_cnt), 64'(v.ed));
    check("enable_cycles", 64'(en_cnt), 64'(v.rc));
    check("enable_bursts", 64'(en_bursts), (v.rc != 0) ? 64'd1 : 64'd0);
    check("dump_words", 64'(dump_cnt), 64'(v.ed));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("stall_cycles", 64'(stall_obs), 64'(v.stall_exp));
    if (v.ei > 0) check("last_iaddr", last_iaddr, 64'(4 * (v.ei - 1)));
    if (v.done_at != 0) check("done_latency", 64'(done_cyc), 64'(v.done_at));
  endtask

  vec_t vecs [6];
  vec_t fresh;
  bit   seen;

  initial begin
    //         il      dl      rc   tog stall ei   ed  st dn
    vecs[0] = '{9'd3,   9'd2,   32'd5, 0, 0, 3,   2,   0, 0};
    vecs[1] = '{9'd4,   9'd0,   32'd3, 1, 0, 4,   0,   0, 0};
    vecs[2] = '{9'd0,   9'd0,   32'd0, 0, 0, 0,   0,   0, 2};
    vecs[3] = '{9'd300, 9'd2,   32'd1, 0, 0, 128, 2,   0, 0};
    vecs[4] = '{9'd0,   9'd3,   32'd0, 0, 1, 0,   3,   4, 0};
    vecs[5] = '{9'd2,   9'd200, 32'd0, 0, 0, 2,   128, 0, 0};

    srst = 1'b1; start = 1'b0; imem_len = '0; dmem_len = '0; run_cycles = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    srst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int i = 0; i < 6; i++) run_session(vecs[i]);

    // Reset on the third RUN cycle, then a fresh session.
    mon_on = 0;
    @(negedge clk);
    imem_len = 9'd0; dmem_len = 9'd0; run_cycles = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      if (cpu_enable) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("run_reached", {63'd0, seen}, 64'd1);
    repeat (2) @(negedge clk);
    check("third_run_cycle", {63'd0, cpu_enable}, 64'd1);
    srst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_run_reset");
    srst = 1'b0;
    @(negedge clk);
    check("no_resume", {63'd0, busy | cpu_enable}, 64'd0);
    fresh = '{9'd1, 9'd1, 32'd2, 0, 0, 1, 1, 0, 0};
    run_session(fresh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_mem_loader.md
CPU_MEM_LOADER -- requirements
Module: cpu_mem_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 128, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 128, data-memory capacity in 64-bit words.
REQ-003 SHALL have one clock and a synchronous, active-high reset; no other clock or reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 srst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a load/run/dump session.
REQ-007 imem_len  in  9  number of instruction words to load.
REQ-008 dmem_len  in  9  number of data words to load, and to dump afterwards.
REQ-009 run_cycles  in  32  number of cycles cpu_enable is held high.
REQ-010 in_valid / in_ready  in / out  1 / 1  host word-stream handshake.
REQ-011 in_data  in  64  host word; bits [31:0] are used for instruction words.
REQ-012 out_valid / out_ready  out / in  1 / 1  dump-stream handshake.
REQ-013 out_data  out  64  dumped data word.
REQ-014 cpu_enable  out  1  drives the CPU enable input.
REQ-015 addr_ext, wen_ext, ren_ext, wdata_ext  out  64, 1, 1, 32  instruction-memory external port.
REQ-016 addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  64, 1, 1, 64  data-memory external port.
REQ-017 rdata_ext_2  in  64  data-memory read data, valid one cycle after ren_ext_2.
REQ-018 busy / done  out / out  1 / 1  session active / one-cycle completion pulse.

Function
REQ-019 SHALL implement the FSM IDLE -> LOAD_I -> LOAD_D -> RUN -> DUMP_RD -> DUMP_WAIT -> DUMP_OUT -> DONE -> IDLE.
REQ-020 SHALL leave IDLE only on start=1; start in any other state SHALL be ignored.
REQ-021 SHALL latch imem_len, dmem_len and run_cycles on start; later input changes SHALL have no effect on the session.
REQ-022 SHALL clamp latched lengths to IMEM_WORDS and DMEM_WORDS respectively.
REQ-023 SHALL skip any state whose count is 0: LOAD_I when imem_len=0; LOAD_D and all DUMP states when dmem_len=0; RUN when run_cycles=0.
REQ-024 SHALL hold in_ready=1 only in LOAD_I and LOAD_D, and SHALL deassert it in the cycle the last word handshakes.
REQ-025 On the handshake of word k in LOAD_I: in the next cycle, wen_ext=1 for exactly one cycle, addr_ext=4*k, wdata_ext=in_data[31:0].
REQ-026 On the handshake of word k in LOAD_D: in the next cycle, wen_ext_2=1 for exactly one cycle, addr_ext_2=8*k, wdata_ext_2=in_data.
REQ-027 SHALL hold cpu_enable=1 for exactly run_cycles consecutive cycles in RUN, and 0 in every other state.
REQ-028 SHALL not assert any wen_ext, wen_ext_2 or ren_ext_2 while cpu_enable=1.
REQ-029 DUMP_RD SHALL assert ren_ext_2=1 for one cycle with addr_ext_2=8*k.
REQ-030 DUMP_WAIT SHALL capture rdata_ext_2 into out_data.
REQ-031 DUMP_OUT SHALL hold out_valid=1 and out_data stable until out_ready=1, then advance k: back to DUMP_RD, or to DONE after word dmem_len-1.
REQ-032 SHALL produce dump words in ascending address order, each exactly once.
REQ-033 Word counter SHALL be 9 bits and SHALL never wrap within a session.
REQ-034 ren_ext SHALL be held 0 at all times.
REQ-035 In every cycle where no port strobe is active, address and write-data outputs SHALL be 0.
REQ-036 busy SHALL be 1 in every state except IDLE.
REQ-037 done SHALL pulse for exactly one cycle in DONE; the FSM SHALL then return to IDLE.

Reset
REQ-038 srst=1 SHALL return the FSM to IDLE on the next rising edge from any state, including mid-load, mid-run and mid-dump.
REQ-039 During and after reset, all outputs SHALL be 0: cpu_enable, in_ready, out_valid, busy, done, all strobes, addresses and data.
REQ-040 A session interrupted by reset SHALL not resume; a new start is required.

Verification
REQ-041 imem_len=3, dmem_len=2, run_cycles=5; host sends I0..I2, D0..D1 with in_valid always 1 -> wen_ext at addresses 0,4,8; wen_ext_2 at addresses 0,8; cpu_enable high exactly 5 cycles; two dump words; done pulses once.
REQ-042 Host in_valid toggling 1/0 during LOAD_I -> exactly one write per accepted word, with no duplicated or skipped addresses.
REQ-043 out_ready held 0 for 4 cycles on the first dump word -> out_valid and out_data stable throughout; dumped words equal the pre-loaded memory contents in order.
REQ-044 imem_len=0, dmem_len=0, run_cycles=0 -> FSM goes directly to DONE; done pulses 2 cycles after start; no strobes.
REQ-045 srst asserted on the 3rd RUN cycle -> cpu_enable=0 and busy=0 on the next edge; a start 1 cycle later begins a fresh session.
REQ-046 imem_len=300 -> exactly 128 instruction writes, with last address 508.
